wb_writeback_queue: RTL and testbench

WB_WRITEBACK_QUEUE -- requirements
Module: WB_writeback_queue

---
 rtl/wb_writeback_queue.sv | 133 +++++++++++++
 tb/tb_wb_writeback_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_writeback_queue.sv
// Writeback queue between execute and the regfile write port: FIFO of results with
// registered write-port outputs and youngest-entry forwarding for decode-stage lookups.
module wb_writeback_queue #(
    parameter int unsigned REG_DATA_WIDTH     = 32,
    parameter int unsigned REGFILE_ADDR_WIDTH = 5,
    parameter int unsigned DEPTH              = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          In_valid,
    output logic                          In_ready,
    input  logic [REGFILE_ADDR_WIDTH-1:0] In_rd_addr,
    input  logic [REG_DATA_WIDTH-1:0]     In_rd_data,
    input  logic                          Wb_stall,
    output logic [REGFILE_ADDR_WIDTH-1:0] Rd_addr,
    output logic [REG_DATA_WIDTH-1:0]     Rd_wr_data,
    output logic                          Rd_wr_en,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Rs2_addr,
    output logic                          Rs1_pending,
    output logic                          Rs2_pending,
    output logic [REG_DATA_WIDTH-1:0]     Rs1_fwd_data,
    output logic [REG_DATA_WIDTH-1:0]     Rs2_fwd_data,
    output logic [$clog2(DEPTH):0]        Count,
    output logic                          Empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [REGFILE_ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [REGFILE_ADDR_WIDTH-1:0] addr_mem_d [DEPTH];
    logic [REG_DATA_WIDTH-1:0]     data_mem_q [DEPTH];
    logic [REG_DATA_WIDTH-1:0]     data_mem_d [DEPTH];

    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [REG_DATA_WIDTH-1:0]     rd_wr_data_q, rd_wr_data_d;
    logic                          rd_wr_en_q, rd_wr_en_d;

    logic accept;
    logic store;
    logic pop;

    assign In_ready   = (count_q != CNT_W'(DEPTH));
    assign Empty      = (count_q == '0);
    assign Count      = count_q;
    assign Rd_addr    = rd_addr_q;
    assign Rd_wr_data = rd_wr_data_q;
    assign Rd_wr_en   = rd_wr_en_q;

    // x0 results complete the handshake but never occupy an entry.
    assign accept = In_valid && In_ready;
    assign store  = accept && (In_rd_addr != '0);
    assign pop    = (count_q != '0) && !Wb_stall;

    always_comb begin
        addr_mem_d   = addr_mem_q;
        data_mem_d   = data_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rd_addr_d    = rd_addr_q;
        rd_wr_data_d = rd_wr_data_q;
        rd_wr_en_d   = 1'b0;
        if (store) begin
            addr_mem_d[wr_ptr_q] = In_rd_addr;
            data_mem_d[wr_ptr_q] = In_rd_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_addr_d    = addr_mem_q[rd_ptr_q];
            rd_wr_data_d = data_mem_q[rd_ptr_q];
            rd_wr_en_d   = 1'b1;
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        end
        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match wins; popped entries are already gone.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = '0;
        Rs1_pending  = 1'b0;
        Rs2_pending  = 1'b0;
        Rs1_fwd_data = '0;
        Rs2_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (Rs1_addr != '0 && addr_mem_q[idx] == Rs1_addr) begin
                    Rs1_pending  = 1'b1;
                    Rs1_fwd_data = data_mem_q[idx];
                end
                if (Rs2_addr != '0 && addr_mem_q[idx] == Rs2_addr) begin
                    Rs2_pending  = 1'b1;
                    Rs2_fwd_data = data_mem_q[idx];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_addr_q    <= '0;
            rd_wr_data_q <= '0;
            rd_wr_en_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_addr_q    <= rd_addr_d;
            rd_wr_data_q <= rd_wr_data_d;
            rd_wr_en_q   <= rd_wr_en_d;
        end
    end

    // Storage needs no reset: entries are only visible below count_q.
    always_ff @(posedge Clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: tb/tb_wb_writeback_queue.sv
// Randomized and directed bench for wb_writeback_queue against a queue-based reference model.
module tb_wb_writeback_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        In_valid;
    logic        In_ready;
    logic [4:0]  In_rd_addr;
    logic [31:0] In_rd_data;
    logic        Wb_stall;
    logic [4:0]  Rd_addr;
    logic [31:0] Rd_wr_data;
    logic        Rd_wr_en;
    logic [4:0]  Rs1_addr;
    logic [4:0]  Rs2_addr;
    logic        Rs1_pending;
    logic        Rs2_pending;
    logic [31:0] Rs1_fwd_data;
    logic [31:0] Rs2_fwd_data;
    logic [2:0]  Count;
    logic        Empty;

    wb_writeback_queue #(
        .REG_DATA_WIDTH    (32),
        .REGFILE_ADDR_WIDTH(5),
        .DEPTH             (DEPTH)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .In_valid    (In_valid),
        .In_ready    (In_ready),
        .In_rd_addr  (In_rd_addr),
        .In_rd_data  (In_rd_data),
        .Wb_stall    (Wb_stall),
        .Rd_addr     (Rd_addr),
        .Rd_wr_data  (Rd_wr_data),
        .Rd_wr_en    (Rd_wr_en),
        .Rs1_addr    (Rs1_addr),
        .Rs2_addr    (Rs2_addr),
        .Rs1_pending (Rs1_pending),
        .Rs2_pending (Rs2_pending),
        .Rs1_fwd_data(Rs1_fwd_data),
        .Rs2_fwd_data(Rs2_fwd_data),
        .Count       (Count),
        .Empty       (Empty)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t      model_q[$];
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          model_known = 1'b0;
    int          n_compared  = 0;
    int          n_mismatched = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [4:0] a, output logic p, output logic [31:0] f);
        p = 1'b0;
        f = '0;
        foreach (model_q[i]) begin
            if (a != 0 && model_q[i].addr == a) begin
                p = 1'b1;
                f = model_q[i].data;
            end
        end
    endfunction

    // Drive one cycle: apply inputs, check outputs mid-cycle, clock, then advance the model.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic st, input logic [4:0] r1, input logic [4:0] r2,
                         input logic rn);
        logic        p1, p2, do_pop, do_push;
        logic [31:0] f1, f2;
        entry_t      e;
        In_valid   = v;
        In_rd_addr = a;
        In_rd_data = d;
        Wb_stall   = st;
        Rs1_addr   = r1;
        Rs2_addr   = r2;
        Reset_n    = rn;
        #3;
        if (model_known) begin
            lookup(r1, p1, f1);
            lookup(r2, p2, f2);
            check_eq("in_ready", 64'(In_ready), 64'(model_q.size() != DEPTH));
            check_eq("empty", 64'(Empty), 64'(model_q.size() == 0));
            check_eq("count", 64'(Count), 64'(model_q.size()));
            check_eq("rd_wr_en", 64'(Rd_wr_en), 64'(m_en));
            check_eq("rd_addr", 64'(Rd_addr), 64'(m_addr));
            check_eq("rd_wr_data", 64'(Rd_wr_data), 64'(m_data));
            check_eq("rs1_pending", 64'(Rs1_pending), 64'(p1));
            check_eq("rs1_fwd", 64'(Rs1_fwd_data), 64'(f1));
            check_eq("rs2_pending", 64'(Rs2_pending), 64'(p2));
            check_eq("rs2_fwd", 64'(Rs2_fwd_data), 64'(f2));
        end
        @(posedge Clk);
        if (!rn) begin
            model_q.delete();
            m_en        = 1'b0;
            m_addr      = '0;
            m_data      = '0;
            model_known = 1'b1;
        end else if (model_known) begin
            do_pop  = (model_q.size() != 0) && !st;
            do_push = v && (model_q.size() != DEPTH);
            m_en    = do_pop;
            if (do_pop) begin
                e      = model_q.pop_front();
                m_addr = e.addr;
                m_data = e.data;
            end
            if (do_push && a != 0) model_q.push_back({a, d});
        end
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, r1, r2, 1'b1);
    endtask

    initial begin
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        idle(1, 5'd0, 5'd0);

        // Single write with forwarding the cycle after accept.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 1'b1);
        idle(3, 5'd5, 5'd5);

        // Fill under stall, rejected fifth push, then drain in order.
        for (int i = 1; i <= 5; i++)
            cycle(1'b1, 5'(i), 32'(i), 1'b1, 5'(i), 5'd3, 1'b1);
        idle(6, 5'd2, 5'd4);

        // Youngest match wins for repeated destination.
        cycle(1'b1, 5'd7, 32'h11, 1'b1, 5'd0, 5'd7, 1'b1);
        cycle(1'b1, 5'd7, 32'h22, 1'b1, 5'd0, 5'd7, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 1'b1);
        idle(4, 5'd7, 5'd7);

        // x0 results are accepted and discarded.
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 1'b1);
        idle(3, 5'd0, 5'd0);

        // Streaming with alternating stall exercises pointer wrap and push+pop.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 5'(i + 8), 32'(i * 3 + 100), 1'(i % 2), 5'(i + 7), 5'(i + 8), 1'b1);
        idle(8, 5'd9, 5'd12);

        // Reset mid-operation discards queued entries.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'(i + 20), 32'(i + 500), 1'b1, 5'd21, 5'd22, 1'b1);
        cycle(1'b1, 5'd30, 32'h77, 1'b0, 5'd21, 5'd22, 1'b0);
        idle(4, 5'd21, 5'd20);

        // Randomized traffic with small address space and occasional reset.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 63) != 0));
        idle(6, 5'd1, 5'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
